// File: rtl/modbus_rtu_rx_framer_pkg.sv
// Shared definitions for the Modbus RTU receive framer: state encodings,
// frame_stat bit positions, silence-timing constants and the CRC-16/Modbus byte step.
package modbus_rtu_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RECV  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // frame_stat = {addr_hit, bcast, short, crc_err, gap_err, ovf, rx_err}
  localparam int STAT_RXE   = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_GAP   = 2;
  localparam int STAT_CRC   = 3;
  localparam int STAT_SHORT = 4;
  localparam int STAT_BCAST = 5;
  localparam int STAT_HIT   = 6;

  localparam int MIN_FRAME = 4;

  // Inter-character silence (1.5 characters of 11 bits); fixed 750 us above 19200 baud.
  function automatic int t15_cycles(input int clk_hz, input int baud);
    longint c;
    longint b;
    c = longint'(clk_hz);
    b = longint'(baud);
    if (baud <= 19200) return int'((c * 165) / (b * 10));
    else               return int'((c * 750) / 1000000);
  endfunction

  // Inter-frame silence (3.5 characters of 11 bits); fixed 1750 us above 19200 baud.
  function automatic int t35_cycles(input int clk_hz, input int baud);
    longint c;
    longint b;
    c = longint'(clk_hz);
    b = longint'(baud);
    if (baud <= 19200) return int'((c * 385) / (b * 10));
    else               return int'((c * 1750) / 1000000);
  endfunction

  // One byte of the reflected CRC-16 (poly 0xA001), LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/modbus_rtu_rx_framer_crc16.sv
// Byte-serial CRC-16/Modbus accumulator. Seeds to 0xFFFF on reset or clr;
// the residue over a frame including its own CRC bytes is 0x0000.
module crc16_modbus
  import modbus_rtu_rx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Accumulate one byte per valid strobe; clr reseeds for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        crc <= 16'hFFFF;
    else if (clr)   crc <= 16'hFFFF;
    else if (valid) crc <= crc16_step(crc, data);
  end

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by line silence, buffers the bytes,
// checks the CRC residue and holds one completed frame until the consumer acknowledges.
module modbus_rtu_rx_framer
  import modbus_rtu_rx_framer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 19200,
  parameter int MAX_LEN = 256,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    my_addr,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [AW:0]   frame_len,
  output logic          frame_ok,
  output logic [6:0]    frame_stat,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int T15 = t15_cycles(CLK_HZ, BAUD);
  localparam int T35 = t35_cycles(CLK_HZ, BAUD);
  localparam int SW  = $clog2(T35 + 1);

  localparam logic [SW-1:0] T15_W     = SW'(T15);
  localparam logic [SW-1:0] T35_W     = SW'(T35);
  localparam logic [AW:0]   MAX_LEN_W = (AW+1)'(MAX_LEN);
  localparam logic [AW:0]   MIN_LEN_W = (AW+1)'(MIN_FRAME);

  state_t        state, state_nx;
  logic [SW-1:0] sil_cnt;
  logic [AW:0]   len;
  logic          gap_f, ovf_f, rxe_f;
  logic          dirty;
  logic [7:0]    b0;
  logic [15:0]   crc;
  logic [6:0]    stat_nx;
  logic          ok_nx;
  logic [7:0]    mem [MAX_LEN];

  logic activity, byte_ok, sil_full, in_gap, store, crc_clr, crc_rst, handshake;

  assign activity  = rx_valid | rx_err;
  // A byte flagged with an error in the same cycle is never stored.
  assign byte_ok   = rx_valid & ~rx_err;
  assign sil_full  = (sil_cnt == T35_W);
  assign in_gap    = (sil_cnt > T15_W) && (sil_cnt < T35_W);
  assign store     = byte_ok && ((state == ST_IDLE) || ((state == ST_RECV) && (len < MAX_LEN_W)));
  assign crc_clr   = (state == ST_SYNC) || (state == ST_CHECK) || (state == ST_HOLD);
  assign crc_rst   = ~rst_n;
  assign handshake = frame_valid & frame_ready;

  crc16_modbus u_crc (
    .clk   (clk),
    .rst   (crc_rst),
    .clr   (crc_clr),
    .valid (store),
    .data  (rx_data),
    .crc   (crc)
  );

  // Line silence counter: cleared by any line event, saturates at the inter-frame time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sil_cnt <= '0;
    else if (activity) sil_cnt <= '0;
    else if (!sil_full) sil_cnt <= sil_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nx;
  end

  // Next-state logic. A byte landing exactly as silence saturates keeps RECV open.
  always_comb begin
    state_nx = state;
    case (state)
      ST_SYNC:  if (sil_full) state_nx = ST_IDLE;
      ST_IDLE:  if (activity) state_nx = ST_RECV;
      ST_RECV:  if (sil_full && !activity) state_nx = ST_CHECK;
      ST_CHECK: state_nx = ST_HOLD;
      ST_HOLD:  if (handshake) state_nx = (dirty || activity) ? ST_SYNC : ST_IDLE;
      default:  state_nx = ST_SYNC;
    endcase
  end

  // Frame accumulation: byte count and error flags, cleared before each new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len   <= '0;
      gap_f <= 1'b0;
      ovf_f <= 1'b0;
      rxe_f <= 1'b0;
    end else if ((state == ST_SYNC) || (state == ST_HOLD)) begin
      len   <= '0;
      gap_f <= 1'b0;
      ovf_f <= 1'b0;
      rxe_f <= 1'b0;
    end else if ((state == ST_IDLE) || (state == ST_RECV)) begin
      if (store) len <= len + 1'b1;
      if (rx_err) rxe_f <= 1'b1;
      if ((state == ST_RECV) && byte_ok && in_gap) gap_f <= 1'b1;
      if ((state == ST_RECV) && byte_ok && (len == MAX_LEN_W)) ovf_f <= 1'b1;
    end
  end

  // Address byte copy so the CHECK cycle needs no second RAM read port.
  always_ff @(posedge clk) begin
    if (store && (len == '0)) b0 <= rx_data;
  end

  // Line activity while a frame is held means the next frame start is unknown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 dirty <= 1'b0;
    else if (state != ST_HOLD)  dirty <= 1'b0;
    else if (activity)          dirty <= 1'b1;
  end

  // Status for the frame being closed. An empty frame has no address byte to match.
  always_comb begin
    stat_nx             = '0;
    stat_nx[STAT_RXE]   = rxe_f;
    stat_nx[STAT_OVF]   = ovf_f;
    stat_nx[STAT_GAP]   = gap_f;
    stat_nx[STAT_CRC]   = (crc != 16'h0000);
    stat_nx[STAT_SHORT] = (len < MIN_LEN_W);
    stat_nx[STAT_BCAST] = (len != '0) && (b0 == 8'h00);
    stat_nx[STAT_HIT]   = (len != '0) && (b0 == my_addr);
    ok_nx = ~stat_nx[STAT_CRC] & ~stat_nx[STAT_SHORT] & ~gap_f & ~ovf_f & ~rxe_f;
  end

  // Output latch: captured in CHECK, frozen through HOLD, valid dropped on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_ok    <= 1'b0;
      frame_stat  <= '0;
    end else if (state == ST_CHECK) begin
      frame_valid <= 1'b1;
      frame_len   <= len;
      frame_ok    <= ok_nx;
      frame_stat  <= stat_nx;
    end else if ((state == ST_HOLD) && handshake) begin
      frame_valid <= 1'b0;
    end
  end

  // Frame buffer write port.
  always_ff @(posedge clk) begin
    if (store) mem[len[AW-1:0]] <= rx_data;
  end

  // Registered read port; addresses beyond the buffer read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rd_data <= '0;
    else if ({1'b0, rd_addr} < MAX_LEN_W) rd_data <= mem[rd_addr];
    else                                rd_data <= '0;
  end

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Directed bench for modbus_rtu_rx_framer at 1 MHz / 9600 baud (T15=1718, T35=4010).
module tb_modbus_rtu_rx_framer;
  import modbus_rtu_rx_framer_pkg::*;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 9600;
  localparam int MAX_LEN = 256;
  localparam int AW      = 8;
  localparam int T35     = 4010;

  logic          clk;
  logic          rst_n;
  logic [7:0]    my_addr;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          frame_valid;
  logic          frame_ready;
  logic [AW:0]   frame_len;
  logic          frame_ok;
  logic [6:0]    frame_stat;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] fb [0:15];

  modbus_rtu_rx_framer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(MAX_LEN), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .my_addr(my_addr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_ok(frame_ok), .frame_stat(frame_stat),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge, spacing cycles later.
  task automatic send_byte(input logic [7:0] b, input logic err, input int spacing);
    rx_data = b; rx_valid = 1'b1; rx_err = err;
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
    repeat (spacing - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input int spacing, input int gap_after, input int gap, input int err_idx);
    int sp;
    for (int i = 0; i < n; i++) begin
      sp = (i == n - 1) ? 1 : ((i == gap_after) ? gap : spacing);
      send_byte(fb[i], (i == err_idx), sp);
    end
  endtask

  task automatic wait_frame(input string tag, output int lat);
    lat = 0;
    while (frame_valid !== 1'b1 && lat < 6000) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 32'(frame_valid), 32'd1);
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic ack(input string tag);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk(tag, 32'(frame_valid), 32'd0);
  endtask

  task automatic set_std(input logic [7:0] last);
    fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'h00; fb[3] = 8'h00;
    fb[4] = 8'h00; fb[5] = 8'h0A; fb[6] = 8'hC5; fb[7] = last;
  endtask

  // Bit-serial reference CRC-16/Modbus over fb[0..n-1].
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic        f;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        f = c[0] ^ fb[i][k];
        c = c >> 1;
        if (f) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  initial begin
    int lat;
    logic [15:0] c;
    logic [7:0] bv;

    rst_n = 1'b0; my_addr = 8'h01; rx_data = 8'h00; rx_valid = 1'b0;
    rx_err = 1'b0; frame_ready = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_len",   32'(frame_len),   32'd0);
    chk("rst_ok",    32'(frame_ok),    32'd0);
    chk("rst_stat",  32'(frame_stat),  32'd0);
    chk("rst_rd",    32'(rd_data),     32'd0);
    rst_n = 1'b1;
    repeat (4020) @(negedge clk);

    // Good frame, 1000-cycle spacing, addressed to us
    set_std(8'hCD);
    send_frame(8, 1000, -1, 0, -1);
    wait_frame("t1_valid", lat);
    chk("t1_latency", 32'(lat), 32'(T35 + 2));
    chk("t1_len",  32'(frame_len),  32'd8);
    chk("t1_ok",   32'(frame_ok),   32'd1);
    chk("t1_stat", 32'(frame_stat), 32'b1000000);
    read_chk("t1_rd5", 8'd5, 8'h0A);
    read_chk("t1_rd0", 8'd0, 8'h01);
    read_chk("t1_rd7", 8'd7, 8'hCD);
    ack("t1_ack");

    // Corrupted CRC
    set_std(8'hCC);
    send_frame(8, 100, -1, 0, -1);
    wait_frame("t2_valid", lat);
    chk("t2_len",  32'(frame_len),  32'd8);
    chk("t2_ok",   32'(frame_ok),   32'd0);
    chk("t2_stat", 32'(frame_stat), 32'b1001000);
    ack("t2_ack");

    // 3000-cycle gap between bytes 4 and 5
    set_std(8'hCD);
    send_frame(8, 100, 3, 3000, -1);
    wait_frame("t3_valid", lat);
    chk("t3_len",  32'(frame_len),  32'd8);
    chk("t3_ok",   32'(frame_ok),   32'd0);
    chk("t3_stat", 32'(frame_stat), 32'b1000100);
    ack("t3_ack");

    // Byte 2 arrives with a line error: flagged and not stored
    set_std(8'hCD);
    send_frame(8, 100, -1, 0, 2);
    wait_frame("rxe_valid", lat);
    chk("rxe_len", 32'(frame_len), 32'd7);
    chk("rxe_ok",  32'(frame_ok),  32'd0);
    chk("rxe_bit", 32'(frame_stat[STAT_RXE]), 32'd1);
    read_chk("rxe_rd4", 8'd4, 8'h0A);
    ack("rxe_ack");

    // MAX_LEN+3 bytes: overflow, extra bytes discarded
    for (int i = 0; i < MAX_LEN + 3; i++) begin
      bv = 8'(i + 5);
      send_byte(bv, 1'b0, (i == MAX_LEN + 2) ? 1 : 10);
    end
    wait_frame("ovf_valid", lat);
    chk("ovf_len", 32'(frame_len), 32'(MAX_LEN));
    chk("ovf_ok",  32'(frame_ok),  32'd0);
    chk("ovf_bit", 32'(frame_stat[STAT_OVF]), 32'd1);
    chk("ovf_short", 32'(frame_stat[STAT_SHORT]), 32'd0);
    read_chk("ovf_rd255", 8'd255, 8'h04);
    read_chk("ovf_rd0",   8'd0,   8'h05);
    ack("ovf_ack");

    // Broadcast frame with valid CRC
    fb[0] = 8'h00; fb[1] = 8'h06; fb[2] = 8'h00; fb[3] = 8'h01; fb[4] = 8'h00; fb[5] = 8'h03;
    c = crc_model(6);
    fb[6] = c[7:0]; fb[7] = c[15:8];
    send_frame(8, 100, -1, 0, -1);
    wait_frame("bc_valid", lat);
    chk("bc_ok",   32'(frame_ok),   32'd1);
    chk("bc_stat", 32'(frame_stat), 32'b0100000);
    ack("bc_ack");

    // Three-byte frame with correct CRC is still short
    fb[0] = 8'h01;
    c = crc_model(1);
    fb[1] = c[7:0]; fb[2] = c[15:8];
    send_frame(3, 100, -1, 0, -1);
    wait_frame("sh_valid", lat);
    chk("sh_len",  32'(frame_len),  32'd3);
    chk("sh_ok",   32'(frame_ok),   32'd0);
    chk("sh_stat", 32'(frame_stat), 32'b1010000);
    ack("sh_ack");

    // Activity during HOLD: frame frozen, ack returns to SYNC
    set_std(8'hCD);
    send_frame(8, 100, -1, 0, -1);
    wait_frame("h_valid", lat);
    send_byte(8'h11, 1'b0, 50);
    send_byte(8'h22, 1'b0, 50);
    chk("h_still", 32'(frame_valid), 32'd1);
    chk("h_len",   32'(frame_len),   32'd8);
    chk("h_stat",  32'(frame_stat),  32'b1000000);
    read_chk("h_rd0", 8'd0, 8'h01);
    ack("h_ack");
    send_frame(8, 100, -1, 0, -1);
    repeat (T35 + 100) @(negedge clk);
    chk("h_sync_ignored", 32'(frame_valid), 32'd0);
    fb[0] = 8'h00; fb[1] = 8'h06; fb[2] = 8'h00; fb[3] = 8'h01; fb[4] = 8'h00; fb[5] = 8'h03;
    c = crc_model(6);
    fb[6] = c[7:0]; fb[7] = c[15:8];
    send_frame(8, 100, -1, 0, -1);
    wait_frame("h_next_valid", lat);
    chk("h_next_stat", 32'(frame_stat), 32'b0100000);
    ack("h_next_ack");

    // Reset in the middle of a frame
    set_std(8'hCD);
    rd_addr = 8'd1;
    send_frame(4, 100, -1, 0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_valid", 32'(frame_valid), 32'd0);
    chk("r_len",   32'(frame_len),   32'd0);
    chk("r_ok",    32'(frame_ok),    32'd0);
    chk("r_stat",  32'(frame_stat),  32'd0);
    chk("r_rd",    32'(rd_data),     32'd0);
    rst_n = 1'b1;
    repeat (4020) @(negedge clk);
    send_frame(8, 100, -1, 0, -1);
    wait_frame("r2_valid", lat);
    chk("r2_len",  32'(frame_len),  32'd8);
    chk("r2_ok",   32'(frame_ok),   32'd1);
    chk("r2_stat", 32'(frame_stat), 32'b1000000);
    read_chk("r2_rd1", 8'd1, 8'h03);
    ack("r2_ack");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
